// File: rtl/ahbl_cmd_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_cmd_master_pkg
// Description : AHB-lite encodings and the alignment helper used by the
//               command master.
// Revision    : 1.0  initial release
// ============================================================================
package ahbl_cmd_master_pkg;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;

    localparam logic [2:0] c_hsize_byte = 3'd0;
    localparam logic [2:0] c_hsize_half = 3'd1;
    localparam logic [2:0] c_hsize_word = 3'd2;

    localparam logic [2:0] c_hburst_single = 3'b000;
    localparam logic [3:0] c_hprot_data    = 4'b0011;

    // Sizes beyond a word are not supported on a 32-bit bus and are treated
    // the same as a misaligned request.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lsb);
        return (size > c_hsize_word) ||
               ((size == c_hsize_half) && lsb[0]) ||
               ((size == c_hsize_word) && (lsb != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahbl_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_cmd_master
// Description : Single-transfer AHB-lite initiator. Converts a valid/ready
//               command stream into pipelined NONSEQ/SINGLE transfers and
//               returns in-order responses.
// Revision    : 1.0  initial release
// ============================================================================
import ahbl_cmd_master_pkg::*;

module ahbl_cmd_master #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [W_DATA-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [W_DATA-1:0] rsp_rdata,
    output logic [1:0]        ahblm_htrans,
    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    output logic              ahblm_hmastlock,
    output logic [W_DATA-1:0] ahblm_hwdata,
    input  logic              ahblm_hready,
    input  logic              ahblm_hresp,
    input  logic [W_DATA-1:0] ahblm_hrdata
);

    // Address-phase slot: its fields are the bus address-phase registers.
    logic              r_a_valid;
    logic              r_a_write;
    logic [W_ADDR-1:0] r_a_addr;
    logic [2:0]        r_a_size;
    logic [W_DATA-1:0] r_a_wdata;
    logic [1:0]        r_htrans;

    // Data-phase slot.
    logic              r_d_valid;
    logic              r_d_write;
    logic [W_DATA-1:0] r_d_wdata;

    logic              r_err_hold;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [W_DATA-1:0] r_rsp_rdata;

    logic w_misaligned;
    logic w_a_issued;
    logic w_accept;
    logic w_a_valid_n;
    logic w_err_hold_n;

    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    // A is only on the bus while NONSEQ is driven; during err_hold it is masked.
    assign w_a_issued   = (r_htrans == c_htrans_nonseq);

    assign req_ready = rst_n && !r_err_hold && (!r_a_valid || ahblm_hready) &&
                       !(w_misaligned && (r_a_valid || r_d_valid));
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_a_valid_n  = r_a_valid;
        w_err_hold_n = r_err_hold;
        if (w_accept && !w_misaligned) begin
            w_a_valid_n = 1'b1;
        end else if (ahblm_hready && w_a_issued) begin
            w_a_valid_n = 1'b0;
        end
        // First ERROR cycle arms the hold; any completing cycle releases it.
        if (ahblm_hready) begin
            w_err_hold_n = 1'b0;
        end else if (ahblm_hresp && r_d_valid) begin
            w_err_hold_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_valid   <= 1'b0;
            r_a_write   <= 1'b0;
            r_a_addr    <= '0;
            r_a_size    <= 3'd0;
            r_a_wdata   <= '0;
            r_htrans    <= c_htrans_idle;
            r_d_valid   <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_wdata   <= '0;
            r_err_hold  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_a_valid   <= w_a_valid_n;
            r_err_hold  <= w_err_hold_n;
            r_htrans    <= (w_a_valid_n && !w_err_hold_n) ? c_htrans_nonseq : c_htrans_idle;

            if (ahblm_hready) begin
                if (r_d_valid) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= ahblm_hresp;
                    r_rsp_rdata <= (!r_d_write && !ahblm_hresp) ? ahblm_hrdata : '0;
                end
                r_d_valid <= w_a_issued;
                if (w_a_issued) begin
                    r_d_write <= r_a_write;
                    r_d_wdata <= r_a_wdata;
                end
            end

            // Misaligned commands only enter with an empty pipeline, so their
            // response can never collide with a data-phase completion.
            if (w_accept) begin
                if (w_misaligned) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                end else begin
                    r_a_write <= req_write;
                    r_a_addr  <= req_addr;
                    r_a_size  <= req_size;
                    r_a_wdata <= req_wdata;
                end
            end
        end
    end

    assign rsp_valid       = r_rsp_valid;
    assign rsp_err         = r_rsp_err;
    assign rsp_rdata       = r_rsp_rdata;
    assign ahblm_htrans    = r_htrans;
    assign ahblm_haddr     = r_a_addr;
    assign ahblm_hwrite    = r_a_write;
    assign ahblm_hsize     = r_a_size;
    assign ahblm_hburst    = c_hburst_single;
    assign ahblm_hprot     = c_hprot_data;
    assign ahblm_hmastlock = 1'b0;
    assign ahblm_hwdata    = r_d_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahbl_cmd_master
// Description : Directed self-checking bench for ahbl_cmd_master.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ahbl_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  ahblm_htrans;
    logic [31:0] ahblm_haddr;
    logic        ahblm_hwrite;
    logic [2:0]  ahblm_hsize;
    logic [2:0]  ahblm_hburst;
    logic [3:0]  ahblm_hprot;
    logic        ahblm_hmastlock;
    logic [31:0] ahblm_hwdata;
    logic        ahblm_hready;
    logic        ahblm_hresp;
    logic [31:0] ahblm_hrdata;

    int n_checks = 0;
    int n_errors = 0;

    ahbl_cmd_master #(.W_ADDR(32), .W_DATA(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .ahblm_htrans(ahblm_htrans), .ahblm_haddr(ahblm_haddr), .ahblm_hwrite(ahblm_hwrite),
        .ahblm_hsize(ahblm_hsize), .ahblm_hburst(ahblm_hburst), .ahblm_hprot(ahblm_hprot),
        .ahblm_hmastlock(ahblm_hmastlock), .ahblm_hwdata(ahblm_hwdata),
        .ahblm_hready(ahblm_hready), .ahblm_hresp(ahblm_hresp), .ahblm_hrdata(ahblm_hrdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        req_wdata = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = 3'd0;
        req_wdata = '0; ahblm_hready = 1'b1; ahblm_hresp = 1'b0; ahblm_hrdata = '0;
        step(); step();
        n_checks++; if (ahblm_htrans !== 2'b00) begin n_errors++; $display("FAIL reset_htrans: got %h want 0", ahblm_htrans); end
        n_checks++; if (ahblm_haddr !== 32'h0) begin n_errors++; $display("FAIL reset_haddr: got %h want 0", ahblm_haddr); end
        n_checks++; if (ahblm_hwdata !== 32'h0) begin n_errors++; $display("FAIL reset_hwdata: got %h want 0", ahblm_hwdata); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready_low: got %b want 0", req_ready); end
        n_checks++; if (ahblm_hburst !== 3'b000 || ahblm_hprot !== 4'b0011 || ahblm_hmastlock !== 1'b0) begin n_errors++; $display("FAIL const_ctrl: got burst=%h prot=%h lock=%b", ahblm_hburst, ahblm_hprot, ahblm_hmastlock); end
        rst_n = 1'b1;
        step();
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
    endtask

    task automatic test_read();
        drive_req(1'b0, 32'h0000_1000, 3'd2, 32'h0);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL read_ready: got %b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        n_checks++; if (ahblm_htrans !== 2'b10 || ahblm_haddr !== 32'h1000 || ahblm_hwrite !== 1'b0 || ahblm_hsize !== 3'd2) begin n_errors++; $display("FAIL read_addr_phase: got t=%h a=%h w=%b s=%h want 2/1000/0/2", ahblm_htrans, ahblm_haddr, ahblm_hwrite, ahblm_hsize); end
        step();
        ahblm_hrdata = 32'hDEAD_BEEF;
        n_checks++; if (ahblm_htrans !== 2'b00 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL read_data_phase: got t=%h rv=%b want 0/0", ahblm_htrans, rsp_valid); end
        step();
        ahblm_hrdata = 32'h0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL read_rsp: got v=%b e=%b d=%h want 1/0/deadbeef", rsp_valid, rsp_err, rsp_rdata); end
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL read_rsp_once: got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive_req(1'b1, 32'h100 + 32'(4 * i), 3'd2, 32'(i + 1));
            else req_valid = 1'b0;
            #1;
            if (i < 4) begin
                n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
            end
            e = (i >= 1 && i <= 4) ? 32'h2 : 32'h0;
            n_checks++; if (32'(ahblm_htrans) !== e) begin n_errors++; $display("FAIL b2b_htrans[%0d]: got %h want %h", i, ahblm_htrans, e); end
            if (i >= 1 && i <= 4) begin
                e = 32'h100 + 32'(4 * (i - 1));
                n_checks++; if (ahblm_haddr !== e || ahblm_hwrite !== 1'b1) begin n_errors++; $display("FAIL b2b_haddr[%0d]: got %h want %h", i, ahblm_haddr, e); end
            end
            if (i >= 2 && i <= 5) begin
                e = 32'(i - 1);
                n_checks++; if (ahblm_hwdata !== e) begin n_errors++; $display("FAIL b2b_hwdata[%0d]: got %h want %h", i, ahblm_hwdata, e); end
            end
            e = (i >= 3 && i <= 6) ? 32'h1 : 32'h0;
            n_checks++; if (32'(rsp_valid) !== e || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL b2b_rsp[%0d]: got v=%b e=%b d=%h want v=%0d", i, rsp_valid, rsp_err, rsp_rdata, e); end
            step();
        end
    endtask

    task automatic test_wait_states();
        drive_req(1'b0, 32'h300, 3'd2, 32'h0);
        step();
        drive_req(1'b1, 32'h304, 3'd2, 32'h55);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL ws_queue_ready: got %b want 1", req_ready); end
        step();
        drive_req(1'b1, 32'h308, 3'd2, 32'h66);
        ahblm_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (ahblm_htrans !== 2'b10 || ahblm_haddr !== 32'h304 || ahblm_hwrite !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                n_errors++; $display("FAIL ws_hold[%0d]: got t=%h a=%h w=%b rdy=%b rv=%b want 2/304/1/0/0", i, ahblm_htrans, ahblm_haddr, ahblm_hwrite, req_ready, rsp_valid); end
            step();
        end
        req_valid = 1'b0;
        ahblm_hready = 1'b1;
        ahblm_hrdata = 32'hCAFE_F00D;
        #1;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL ws_release: got rdy=%b rv=%b want 1/0", req_ready, rsp_valid); end
        step();
        ahblm_hrdata = 32'h0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL ws_read_rsp: got v=%b e=%b d=%h want 1/0/cafef00d", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (ahblm_htrans !== 2'b00 || ahblm_hwdata !== 32'h55) begin n_errors++; $display("FAIL ws_write_data: got t=%h wd=%h want 0/55", ahblm_htrans, ahblm_hwdata); end
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL ws_write_rsp: got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL ws_idle: got %b want 0", rsp_valid); end
    endtask

    task automatic test_error();
        drive_req(1'b1, 32'h200, 3'd2, 32'hAA);
        step();
        drive_req(1'b0, 32'h204, 3'd2, 32'h0);
        step();
        req_valid = 1'b0;
        ahblm_hready = 1'b0;
        ahblm_hresp  = 1'b1;
        n_checks++; if (ahblm_htrans !== 2'b10 || ahblm_haddr !== 32'h204 || ahblm_hwdata !== 32'hAA) begin n_errors++; $display("FAIL err_cycle1: got t=%h a=%h wd=%h want 2/204/aa", ahblm_htrans, ahblm_haddr, ahblm_hwdata); end
        step();
        ahblm_hready = 1'b1;
        #1;
        n_checks++; if (ahblm_htrans !== 2'b00 || ahblm_haddr !== 32'h204 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL err_cycle2: got t=%h a=%h rdy=%b rv=%b want 0/204/0/0", ahblm_htrans, ahblm_haddr, req_ready, rsp_valid); end
        step();
        ahblm_hresp = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL err_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (ahblm_htrans !== 2'b10 || ahblm_haddr !== 32'h204 || ahblm_hwrite !== 1'b0) begin n_errors++; $display("FAIL err_retry: got t=%h a=%h w=%b want 2/204/0", ahblm_htrans, ahblm_haddr, ahblm_hwrite); end
        step();
        ahblm_hrdata = 32'h1234;
        n_checks++; if (rsp_valid !== 1'b0 || ahblm_htrans !== 2'b00) begin n_errors++; $display("FAIL err_retry_data: got rv=%b t=%h want 0/0", rsp_valid, ahblm_htrans); end
        step();
        ahblm_hrdata = 32'h0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1234) begin n_errors++; $display("FAIL err_retry_rsp: got v=%b e=%b d=%h want 1/0/1234", rsp_valid, rsp_err, rsp_rdata); end
        step();
    endtask

    task automatic test_misaligned();
        drive_req(1'b0, 32'h400, 3'd2, 32'h0);
        step();
        drive_req(1'b0, 32'h3, 3'd2, 32'h0);
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL mis_block_a: got %b want 0", req_ready); end
        step();
        ahblm_hrdata = 32'h77;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL mis_block_d: got %b want 0", req_ready); end
        step();
        ahblm_hrdata = 32'h0;
        #1;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h77) begin n_errors++; $display("FAIL mis_empty: got rdy=%b rv=%b d=%h want 1/1/77", req_ready, rsp_valid, rsp_rdata); end
        step();
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || ahblm_htrans !== 2'b00) begin n_errors++; $display("FAIL mis_rsp: got v=%b e=%b d=%h t=%h want 1/1/0/0", rsp_valid, rsp_err, rsp_rdata, ahblm_htrans); end
        drive_req(1'b1, 32'h401, 3'd1, 32'h0);
        step();
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || ahblm_htrans !== 2'b00) begin n_errors++; $display("FAIL mis_half_rsp: got v=%b e=%b t=%h want 1/1/0", rsp_valid, rsp_err, ahblm_htrans); end
        drive_req(1'b0, 32'h402, 3'd1, 32'h0);
        step();
        req_valid = 1'b0;
        n_checks++; if (ahblm_htrans !== 2'b10 || ahblm_haddr !== 32'h402 || ahblm_hsize !== 3'd1 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL aligned_half: got t=%h a=%h s=%h rv=%b want 2/402/1/0", ahblm_htrans, ahblm_haddr, ahblm_hsize, rsp_valid); end
        step(); step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_errors++; $display("FAIL aligned_half_rsp: got v=%b e=%b want 1/0", rsp_valid, rsp_err); end
        step();
    endtask

    task automatic test_reset_mid();
        drive_req(1'b0, 32'h500, 3'd2, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        ahblm_hready = 1'b0;
        rst_n = 1'b0;
        step();
        n_checks++; if (ahblm_htrans !== 2'b00 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_clear: got t=%h rv=%b rdy=%b want 0/0/0", ahblm_htrans, rsp_valid, req_ready); end
        rst_n = 1'b1;
        ahblm_hready = 1'b1;
        ahblm_hrdata = 32'hBAD0_BAD0;
        step();
        n_checks++; if (rsp_valid !== 1'b0 || ahblm_htrans !== 2'b00) begin n_errors++; $display("FAIL rstmid_dropped: got rv=%b t=%h want 0/0", rsp_valid, ahblm_htrans); end
        drive_req(1'b0, 32'h600, 3'd2, 32'h0);
        step();
        req_valid = 1'b0;
        n_checks++; if (ahblm_htrans !== 2'b10 || ahblm_haddr !== 32'h600 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_reissue: got t=%h a=%h rv=%b want 2/600/0", ahblm_htrans, ahblm_haddr, rsp_valid); end
        step();
        ahblm_hrdata = 32'h600D_600D;
        step();
        ahblm_hrdata = 32'h0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h600D_600D) begin n_errors++; $display("FAIL rstmid_read: got v=%b e=%b d=%h want 1/0/600d600d", rsp_valid, rsp_err, rsp_rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_misaligned();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
